config_bus_master: RTL and testbench

- Initiator side of the per-tile configuration bus.
- Accepts read/write commands from the global config controller over a valid/ready command channel.
- Sequences them onto a core's config port: config_config_addr, config_config_data, config_read, config_write.
- For reads, samples the core's read_config_data and returns it on a valid/ready response channel. One instance sits in front of each core.

---
 rtl/config_bus_master.sv | 120 ++++++++++++
 tb/tb_config_bus_master.sv | 379 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/config_bus_master.sv
// Per-core config bus initiator; CONFIG_BUS_MASTER_WRITE_VERIFY_EN adds a read-back check after each write.
// Latency: write strobe 1 cycle after acceptance; read data returned READ_LATENCY+1 cycles after the read strobe rises.
// Backpressure: cmd_ready only in IDLE; a response holds rsp_valid/rsp_data until rsp_ready, blocking new commands.
module config_bus_master #(
    parameter int ADDR_WIDTH   = 8,
    parameter int DATA_WIDTH   = 32,
    parameter int READ_LATENCY = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_data,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic [ADDR_WIDTH-1:0] config_config_addr,
    output logic [DATA_WIDTH-1:0] config_config_data,
    output logic                  config_read,
    output logic                  config_write,
    input  logic [DATA_WIDTH-1:0] read_config_data,
    output logic                  busy,
    output logic                  verify_err
);

    localparam int CNT_W = (READ_LATENCY > 0) ? $clog2(READ_LATENCY + 1) : 1;

`ifdef CONFIG_BUS_MASTER_WRITE_VERIFY_EN
    typedef enum logic [2:0] {IDLE, WRITE, READ, RSP, VREAD} state_t;
`else
    typedef enum logic [2:0] {IDLE, WRITE, READ, RSP} state_t;
`endif

    state_t           state;
    logic [CNT_W-1:0] cnt;

    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);

`ifndef CONFIG_BUS_MASTER_WRITE_VERIFY_EN
    assign verify_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state              <= IDLE;
            cnt                <= '0;
            config_read        <= 1'b0;
            config_write       <= 1'b0;
            config_config_addr <= '0;
            config_config_data <= '0;
            rsp_valid          <= 1'b0;
            rsp_data           <= '0;
`ifdef CONFIG_BUS_MASTER_WRITE_VERIFY_EN
            verify_err         <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        config_config_addr <= cmd_addr;
                        config_config_data <= cmd_data;
                        cnt                <= CNT_W'(READ_LATENCY);
                        if (cmd_write) begin
                            state        <= WRITE;
                            config_write <= 1'b1;
                        end else begin
                            state       <= READ;
                            config_read <= 1'b1;
                        end
                    end
                end
                WRITE: begin
                    config_write <= 1'b0;
`ifdef CONFIG_BUS_MASTER_WRITE_VERIFY_EN
                    state       <= VREAD;
                    config_read <= 1'b1;
                    cnt         <= CNT_W'(READ_LATENCY);
`else
                    state <= IDLE;
`endif
                end
                READ: begin
                    // Strobe is dropped on the same edge that captures the readback.
                    if (cnt == '0) begin
                        rsp_data    <= read_config_data;
                        rsp_valid   <= 1'b1;
                        config_read <= 1'b0;
                        state       <= RSP;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                RSP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
`ifdef CONFIG_BUS_MASTER_WRITE_VERIFY_EN
                VREAD: begin
                    if (cnt == '0) begin
                        if (read_config_data != config_config_data) begin
                            verify_err <= 1'b1;
                        end
                        config_read <= 1'b0;
                        state       <= IDLE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_config_bus_master.sv
// Bench for config_bus_master: two instances (READ_LATENCY 0 and 2) in front of a small shared core model.
module tb_config_bus_master;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic        a_cmd_valid, a_cmd_ready, a_cmd_write;
    logic [7:0]  a_cmd_addr;
    logic [31:0] a_cmd_data;
    logic        a_rsp_valid, a_rsp_ready;
    logic [31:0] a_rsp_data;
    logic [7:0]  a_addr;
    logic [31:0] a_wdata, a_rdata;
    logic        a_rd, a_wr, a_busy, a_verr;

    logic        b_cmd_valid, b_cmd_ready, b_cmd_write;
    logic [7:0]  b_cmd_addr;
    logic [31:0] b_cmd_data;
    logic        b_rsp_valid, b_rsp_ready;
    logic [31:0] b_rsp_data;
    logic [7:0]  b_addr;
    logic [31:0] b_wdata, b_rdata;
    logic        b_rd, b_wr, b_busy, b_verr;

    config_bus_master #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .READ_LATENCY(0)) dut_a (
        .clk(clk), .reset(reset),
        .cmd_valid(a_cmd_valid), .cmd_ready(a_cmd_ready), .cmd_write(a_cmd_write),
        .cmd_addr(a_cmd_addr), .cmd_data(a_cmd_data),
        .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready), .rsp_data(a_rsp_data),
        .config_config_addr(a_addr), .config_config_data(a_wdata),
        .config_read(a_rd), .config_write(a_wr), .read_config_data(a_rdata),
        .busy(a_busy), .verify_err(a_verr)
    );

    config_bus_master #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .READ_LATENCY(2)) dut_b (
        .clk(clk), .reset(reset),
        .cmd_valid(b_cmd_valid), .cmd_ready(b_cmd_ready), .cmd_write(b_cmd_write),
        .cmd_addr(b_cmd_addr), .cmd_data(b_cmd_data),
        .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_data(b_rsp_data),
        .config_config_addr(b_addr), .config_config_data(b_wdata),
        .config_read(b_rd), .config_write(b_wr), .read_config_data(b_rdata),
        .busy(b_busy), .verify_err(b_verr)
    );

    // Core: 0x00-0x03 read/write registers, 0x04 read-only constant 0xA, everything else reads 0.
    logic [31:0] mem [0:3];
    logic [31:0] sh  [0:3];

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) mem[i] <= '0;
        end else begin
            if (a_wr && a_addr < 8'd4) mem[a_addr[1:0]] <= a_wdata;
            if (b_wr && b_addr < 8'd4) mem[b_addr[1:0]] <= b_wdata;
        end
    end

    assign a_rdata = (a_addr < 8'd4) ? mem[a_addr[1:0]] : (a_addr == 8'h04) ? 32'h0000000A : 32'h0;
    assign b_rdata = (b_addr < 8'd4) ? mem[b_addr[1:0]] : (b_addr == 8'h04) ? 32'h0000000A : 32'h0;

    function automatic logic [31:0] exp_rd(input logic [7:0] ad);
        if (ad < 8'd4) return sh[ad[1:0]];
        if (ad == 8'h04) return 32'h0000000A;
        return 32'h0;
    endfunction

    logic [31:0] qa[$];
    logic [31:0] qb[$];
    int a_rsp_cnt = 0;
    int b_rsp_cnt = 0;

    always @(negedge clk) begin
        if (!reset) begin
            tests++;
            if ((a_rd && a_wr) || (b_rd && b_wr)) begin
                fails++;
                $display("FAIL strobe_excl: a rd/wr=%b%b b rd/wr=%b%b, required never both 1", a_rd, a_wr, b_rd, b_wr);
            end
            if (a_rsp_valid && a_rsp_ready) begin
                logic [31:0] e;
                a_rsp_cnt++;
                tests++;
                if (qa.size() == 0) begin
                    fails++;
                    $display("FAIL a_rsp_unexpected: got %h, none expected", a_rsp_data);
                end else begin
                    e = qa.pop_front();
                    if (a_rsp_data !== e) begin
                        fails++;
                        $display("FAIL a_rsp_data: got %h want %h", a_rsp_data, e);
                    end
                end
            end
            if (b_rsp_valid && b_rsp_ready) begin
                logic [31:0] e;
                b_rsp_cnt++;
                tests++;
                if (qb.size() == 0) begin
                    fails++;
                    $display("FAIL b_rsp_unexpected: got %h, none expected", b_rsp_data);
                end else begin
                    e = qb.pop_front();
                    if (b_rsp_data !== e) begin
                        fails++;
                        $display("FAIL b_rsp_data: got %h want %h", b_rsp_data, e);
                    end
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send_a(input logic w, input logic [7:0] ad, input logic [31:0] d);
        int n = 0;
        a_cmd_valid = 1'b1; a_cmd_write = w; a_cmd_addr = ad; a_cmd_data = d;
        while (!a_cmd_ready && n < 50) begin tick(); n++; end
        tests++;
        if (a_cmd_ready !== 1'b1) begin
            fails++;
            $display("FAIL a_accept_timeout: cmd_ready=%b after %0d cycles, want 1", a_cmd_ready, n);
        end
        if (w) begin
            if (ad < 8'd4) sh[ad[1:0]] = d;
        end else begin
            qa.push_back(exp_rd(ad));
        end
        tick();
        a_cmd_valid = 1'b0;
    endtask

    task automatic wait_idle_a;
        int n = 0;
        while (a_busy && n < 50) begin tick(); n++; end
        tests++;
        if (a_busy !== 1'b0) begin
            fails++;
            $display("FAIL a_idle_timeout: busy=%b, want 0", a_busy);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) sh[i] = '0;
        tests++;
        if ({a_cmd_ready, a_rd, a_wr, a_rsp_valid, a_busy, a_verr} !== 6'b100000) begin
            fails++;
            $display("FAIL reset_ctrl: rdy/rd/wr/rv/busy/verr=%b want 100000",
                     {a_cmd_ready, a_rd, a_wr, a_rsp_valid, a_busy, a_verr});
        end
        tests++;
        if ({a_addr, a_wdata, a_rsp_data} !== 72'h0) begin
            fails++;
            $display("FAIL reset_data: addr=%h wdata=%h rsp=%h want 0", a_addr, a_wdata, a_rsp_data);
        end
        tests++;
        if ({b_cmd_ready, b_rd, b_wr, b_rsp_valid, b_busy} !== 5'b10000) begin
            fails++;
            $display("FAIL reset_b: rdy/rd/wr/rv/busy=%b want 10000", {b_cmd_ready, b_rd, b_wr, b_rsp_valid, b_busy});
        end
    endtask

    task automatic test_write_read;
        send_a(1'b1, 8'h00, 32'hDEADBEEF);
        tests++;
        if ({a_wr, a_rd, a_addr, a_wdata} !== {2'b10, 8'h00, 32'hDEADBEEF}) begin
            fails++;
            $display("FAIL wr_strobe: wr=%b rd=%b addr=%h data=%h want 1 0 00 deadbeef", a_wr, a_rd, a_addr, a_wdata);
        end
        tick();
        tests++;
        if (a_wr !== 1'b0) begin
            fails++;
            $display("FAIL wr_one_cycle: wr=%b want 0", a_wr);
        end
        wait_idle_a();
        send_a(1'b0, 8'h00, 32'h0);
        tests++;
        if ({a_rd, a_rsp_valid} !== 2'b10) begin
            fails++;
            $display("FAIL rd_strobe: rd=%b rsp_valid=%b want 1 0", a_rd, a_rsp_valid);
        end
        tick();
        tests++;
        if ({a_rd, a_rsp_valid, a_rsp_data} !== {2'b01, 32'hDEADBEEF}) begin
            fails++;
            $display("FAIL rd_rsp: rd=%b rsp_valid=%b data=%h want 0 1 deadbeef", a_rd, a_rsp_valid, a_rsp_data);
        end
        tick();
        tests++;
        if ({a_rsp_valid, a_cmd_ready} !== 2'b01) begin
            fails++;
            $display("FAIL rsp_single: rsp_valid=%b cmd_ready=%b want 0 1", a_rsp_valid, a_cmd_ready);
        end
    endtask

    task automatic test_backpressure;
        send_a(1'b1, 8'h01, 32'h12345678);
        wait_idle_a();
        a_rsp_ready = 1'b0;
        send_a(1'b0, 8'h01, 32'h0);
        // A write held on the command channel must not be consumed while the response is pending.
        a_cmd_valid = 1'b1; a_cmd_write = 1'b1; a_cmd_addr = 8'h03; a_cmd_data = 32'hCAFEF00D;
        tick();
        for (int i = 0; i < 5; i++) begin
            tests++;
            if ({a_rsp_valid, a_rsp_data, a_cmd_ready, a_wr} !== {1'b1, 32'h12345678, 2'b00}) begin
                fails++;
                $display("FAIL bp_hold[%0d]: rsp_valid=%b data=%h cmd_ready=%b wr=%b want 1 12345678 0 0",
                         i, a_rsp_valid, a_rsp_data, a_cmd_ready, a_wr);
            end
            tick();
        end
        a_cmd_valid = 1'b0;
        a_rsp_ready = 1'b1;
        tests++;
        if (a_cmd_ready !== 1'b0) begin
            fails++;
            $display("FAIL bp_ready_early: cmd_ready=%b want 0", a_cmd_ready);
        end
        tick();
        tests++;
        if ({a_cmd_ready, a_rsp_valid} !== 2'b10) begin
            fails++;
            $display("FAIL bp_release: cmd_ready=%b rsp_valid=%b want 1 0", a_cmd_ready, a_rsp_valid);
        end
        send_a(1'b0, 8'h03, 32'h0);
        wait_idle_a();
    endtask

    task automatic read_b(input logic [7:0] ad);
        int n = 0;
        int hi = 0;
        logic [31:0] e;
        e = exp_rd(ad);
        b_cmd_valid = 1'b1; b_cmd_write = 1'b0; b_cmd_addr = ad; b_cmd_data = '0;
        while (!b_cmd_ready && n < 50) begin tick(); n++; end
        tests++;
        if (b_cmd_ready !== 1'b1) begin
            fails++;
            $display("FAIL b_accept_timeout: cmd_ready=%b want 1", b_cmd_ready);
        end
        qb.push_back(e);
        tick();
        b_cmd_valid = 1'b0;
        n = 0;
        while (!b_rsp_valid && n < 20) begin
            if (b_rd) hi++;
            tick();
            n++;
        end
        tests++;
        if (hi != 3) begin
            fails++;
            $display("FAIL lat_rd_cycles addr %h: config_read high %0d cycles want 3", ad, hi);
        end
        tests++;
        if ({b_rsp_valid, b_rsp_data} !== {1'b1, e}) begin
            fails++;
            $display("FAIL lat_rsp addr %h: rsp_valid=%b data=%h want 1 %h", ad, b_rsp_valid, b_rsp_data, e);
        end
        tick();
    endtask

    task automatic test_read_latency;
        read_b(8'h04);
        read_b(8'h05);
    endtask

    task automatic test_reset_mid_read;
        int c0;
        int n = 0;
        c0 = a_rsp_cnt;
        a_cmd_valid = 1'b1; a_cmd_write = 1'b0; a_cmd_addr = 8'h00; a_cmd_data = '0;
        while (!a_cmd_ready && n < 50) begin tick(); n++; end
        tick();
        a_cmd_valid = 1'b0;
        tests++;
        if (a_rd !== 1'b1) begin
            fails++;
            $display("FAIL mid_in_read: rd=%b want 1", a_rd);
        end
        reset = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) sh[i] = '0;
        tests++;
        if ({a_rd, a_rsp_valid, a_busy, a_cmd_ready} !== 4'b0001) begin
            fails++;
            $display("FAIL mid_reset: rd/rv/busy/rdy=%b want 0001", {a_rd, a_rsp_valid, a_busy, a_cmd_ready});
        end
        reset = 1'b0;
        repeat (6) begin
            tick();
            tests++;
            if (a_rsp_valid !== 1'b0) begin
                fails++;
                $display("FAIL mid_no_rsp: rsp_valid=%b want 0", a_rsp_valid);
            end
        end
        tests++;
        if (a_rsp_cnt != c0) begin
            fails++;
            $display("FAIL mid_rsp_count: got %0d want %0d", a_rsp_cnt, c0);
        end
    endtask

    task automatic test_write_verify;
        send_a(1'b1, 8'h00, 32'h00000011);
        wait_idle_a();
        tests++;
        if (a_verr !== 1'b0) begin
            fails++;
            $display("FAIL verify_good: verify_err=%b want 0", a_verr);
        end
        send_a(1'b1, 8'h07, 32'h00000055);
`ifdef CONFIG_BUS_MASTER_WRITE_VERIFY_EN
        tests++;
        if ({a_wr, a_verr} !== 2'b10) begin
            fails++;
            $display("FAIL verify_strobe: wr=%b verify_err=%b want 1 0", a_wr, a_verr);
        end
        tick();
        tests++;
        if ({a_rd, a_verr} !== 2'b10) begin
            fails++;
            $display("FAIL verify_vread: rd=%b verify_err=%b want 1 0", a_rd, a_verr);
        end
        tick();
        tests++;
        if (a_verr !== 1'b1) begin
            fails++;
            $display("FAIL verify_rise: verify_err=%b want 1", a_verr);
        end
        repeat (3) tick();
        tests++;
        if ({a_verr, a_busy} !== 2'b10) begin
            fails++;
            $display("FAIL verify_sticky: verify_err=%b busy=%b want 1 0", a_verr, a_busy);
        end
`else
        wait_idle_a();
        tests++;
        if (a_verr !== 1'b0) begin
            fails++;
            $display("FAIL verify_tied: verify_err=%b want 0", a_verr);
        end
`endif
    endtask

    initial begin
        a_cmd_valid = 1'b0; a_cmd_write = 1'b0; a_cmd_addr = '0; a_cmd_data = '0; a_rsp_ready = 1'b1;
        b_cmd_valid = 1'b0; b_cmd_write = 1'b0; b_cmd_addr = '0; b_cmd_data = '0; b_rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) sh[i] = '0;
        test_reset();
        test_write_read();
        test_backpressure();
        test_read_latency();
        test_reset_mid_read();
        test_write_verify();
        repeat (3) tick();
        tests++;
        if (qa.size() != 0 || qb.size() != 0) begin
            fails++;
            $display("FAIL rsp_missing: %0d/%0d expected responses never seen, want 0/0", qa.size(), qb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
